// File: rtl/ddr2_local_responder.sv
// DDR2 controller local-interface target backed by on-chip RAM, matching the controller's
// ready / wdata_req / rdata_valid timing. Optional refresh stall: define RESP_REFRESH_STALL_EN.
module ddr2_local_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 25,
    parameter int MEM_AW         = 10,
    parameter int INIT_CYCLES    = 16,
    parameter int RD_LATENCY     = 4,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_STALL  = 8
) (
    input  logic                    phy_clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   local_address,
    input  logic                    local_write_req,
    input  logic                    local_read_req,
    input  logic                    local_burstbegin,
    input  logic [2:0]              local_size,
    input  logic [DATA_WIDTH-1:0]   local_wdata,
    input  logic [DATA_WIDTH/8-1:0] local_be,
    output logic                    local_ready,
    output logic                    local_wdata_req,
    output logic [DATA_WIDTH-1:0]   local_rdata,
    output logic                    local_rdata_valid,
    output logic                    local_init_done
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR_DATA, S_WR_LAST, S_RD_WAIT, S_RD_DATA
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             left_q, left_d;
    logic [MEM_AW-1:0]      addr_q, addr_d;
    logic                   init_done_q, init_done_d;
    logic                   wr_pend_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   stall;
    logic                   accept, accept_wr, accept_rd;
    logic                   mem_we, mem_re;
    logic [2:0]             size_n;
    logic                   unused_addr;

    logic [DATA_WIDTH-1:0]  mem [0:(1<<MEM_AW)-1];

    assign unused_addr = ^local_address[ADDR_WIDTH-1:MEM_AW];

    assign size_n    = (local_size == 3'd0) ? 3'd1 : local_size;
    assign accept    = local_ready & local_burstbegin & (local_write_req | local_read_req);
    assign accept_wr = accept & local_write_req;
    assign accept_rd = accept & ~local_write_req;

    always_ff @(posedge phy_clk) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    if (cnt_q == CNT_W'(INIT_CYCLES - 1)) state_d = S_IDLE;
            S_IDLE: begin
                if (accept_wr)      state_d = S_WR_DATA;
                else if (accept_rd) state_d = S_RD_WAIT;
            end
            S_WR_DATA: if (left_q == 3'd1) state_d = S_WR_LAST;
            S_WR_LAST: state_d = S_IDLE;
            S_RD_WAIT: if (cnt_q == CNT_W'(1)) state_d = S_RD_DATA;
            S_RD_DATA: if (left_q == 3'd1) state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    // A write beat lands the cycle after its wdata_req; a read beat is fetched a cycle ahead.
    always_comb begin
        local_ready       = (state_q == S_IDLE) & init_done_q & ~stall;
        local_wdata_req   = (state_q == S_WR_DATA);
        local_rdata_valid = (state_q == S_RD_DATA);
        mem_we            = wr_pend_q & ~rst;
        mem_re            = ((state_q == S_RD_WAIT) && (cnt_q == CNT_W'(1))) ||
                            ((state_q == S_RD_DATA) && (left_q != 3'd1));
    end

    always_comb begin
        cnt_d       = cnt_q;
        left_d      = left_q;
        addr_d      = addr_q;
        init_done_d = init_done_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) init_done_d = 1'b1;
            end
            S_IDLE: begin
                if (accept) begin
                    left_d = size_n;
                    addr_d = local_address[MEM_AW-1:0];
                    cnt_d  = CNT_W'(RD_LATENCY - 1);
                end
            end
            S_WR_DATA: left_d = left_q - 3'd1;
            S_RD_WAIT: cnt_d  = cnt_q - 1'b1;
            S_RD_DATA: left_d = left_q - 3'd1;
            default: ;
        endcase
        if (mem_we || mem_re) addr_d = addr_q + 1'b1;
    end

    always_ff @(posedge phy_clk) begin
        if (rst) begin
            cnt_q       <= '0;
            left_q      <= '0;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
            wr_pend_q   <= local_wdata_req;
            if (mem_re) rdata_q <= mem[addr_q];
        end
    end

    // RAM contents survive reset; only the enabled bytes of each beat are written.
    always_ff @(posedge phy_clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (local_be[b]) mem[addr_q][b*8 +: 8] <= local_wdata[b*8 +: 8];
            end
        end
    end

    assign local_rdata     = rdata_q;
    assign local_init_done = init_done_q;

`ifdef RESP_REFRESH_STALL_EN
    logic [CNT_W-1:0] ref_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             ref_pend_q;

    // Refresh requests that arrive mid-burst wait for IDLE; a new request wins over the clear.
    always_ff @(posedge phy_clk) begin
        if (rst) begin
            ref_cnt_q   <= '0;
            stall_cnt_q <= '0;
            ref_pend_q  <= 1'b0;
        end else begin
            if (stall_cnt_q != '0) begin
                stall_cnt_q <= stall_cnt_q - 1'b1;
            end else if (ref_pend_q && (state_q == S_IDLE) && !accept) begin
                stall_cnt_q <= CNT_W'(REFRESH_STALL);
                ref_pend_q  <= 1'b0;
            end
            if (init_done_q) begin
                if (ref_cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
                    ref_cnt_q  <= '0;
                    ref_pend_q <= 1'b1;
                end else begin
                    ref_cnt_q <= ref_cnt_q + 1'b1;
                end
            end
        end
    end

    assign stall = (stall_cnt_q != '0);
`else
    localparam int unused_refresh = REFRESH_PERIOD + REFRESH_STALL;
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_local_responder.sv
// Bench for ddr2_local_responder: a cycle-indexed expectation schedule built from the burst
// timing rules plus a word-array memory model, checked every cycle, with literal spot checks.
module tb_ddr2_local_responder;
    localparam int DW   = 32;
    localparam int AW   = 25;
    localparam int MAW  = 10;
    localparam int MD   = 1 << MAW;
    localparam int INIT = 16;
    localparam int RL   = 4;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] local_address = '0;
    logic          local_write_req = 1'b0;
    logic          local_read_req = 1'b0;
    logic          local_burstbegin = 1'b0;
    logic [2:0]    local_size = '0;
    logic [DW-1:0] local_wdata = '0;
    logic [3:0]    local_be = '0;
    logic          local_ready;
    logic          local_wdata_req;
    logic [DW-1:0] local_rdata;
    logic          local_rdata_valid;
    logic          local_init_done;

    ddr2_local_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW), .INIT_CYCLES(INIT),
        .RD_LATENCY(RL), .REFRESH_PERIOD(64), .REFRESH_STALL(8)
    ) dut (
        .phy_clk(clk), .rst(rst), .local_address(local_address),
        .local_write_req(local_write_req), .local_read_req(local_read_req),
        .local_burstbegin(local_burstbegin), .local_size(local_size),
        .local_wdata(local_wdata), .local_be(local_be), .local_ready(local_ready),
        .local_wdata_req(local_wdata_req), .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected behaviour per absolute cycle
    bit            busy [MAXC];
    bit            wreq [MAXC];
    bit            rv   [MAXC];
    logic [DW-1:0] rd   [MAXC];
    logic [DW-1:0] mmem [MD];
    int            init_start = 0;
    bit            chk_en = 1'b0;
    logic [DW-1:0] exp_last = '0;
    bit            exp_init;
    bit            exp_rdy;

    logic [DW-1:0] wdat [8];
    logic [3:0]    wbe  [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_ready(input int c);
        return (c >= init_start + INIT) && !busy[c];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            exp_init = (cyc >= init_start + INIT);
            exp_rdy  = model_ready(cyc);
            if (cyc == init_start) exp_last = '0;
            if (rv[cyc]) exp_last = rd[cyc];
            chk("init_done", {31'b0, local_init_done}, {31'b0, exp_init});
            chk("ready", {31'b0, local_ready}, {31'b0, exp_rdy});
            chk("wdata_req", {31'b0, local_wdata_req}, {31'b0, wreq[cyc]});
            chk("rdata_valid", {31'b0, local_rdata_valid}, {31'b0, rv[cyc]});
            chk("rdata", local_rdata, exp_last);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic wait_ready(output int t);
        int k;
        k = 0;
        while (!model_ready(cyc) && k < 200) begin
            next_cycle();
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ready at cycle %0d: got no ready, expected ready within 200 cycles", cyc);
        end
        t = cyc;
    endtask

    task automatic do_write(input int addr, input int size, input bit also_rd, output int t);
        int n;
        n = (size == 0) ? 1 : size;
        local_address    = AW'(addr);
        local_size       = 3'(size);
        local_write_req  = 1'b1;
        local_read_req   = also_rd;
        local_burstbegin = 1'b1;
        wait_ready(t);
        for (int c = t + 1; c <= t + n + 1; c++) busy[c] = 1'b1;
        for (int c = t + 1; c <= t + n; c++) wreq[c] = 1'b1;
        next_cycle();
        local_write_req = 1'b0;
        if (!also_rd) begin
            local_read_req   = 1'b0;
            local_burstbegin = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            next_cycle();
            local_wdata = wdat[k];
            local_be    = wbe[k];
            for (int b = 0; b < 4; b++)
                if (wbe[k][b]) mmem[(addr + k) % MD][b*8 +: 8] = wdat[k][b*8 +: 8];
        end
        next_cycle();
        local_wdata = '0;
        local_be    = '0;
    endtask

    task automatic do_read(input int addr, input int size, output int u);
        int n;
        n = (size == 0) ? 1 : size;
        local_address    = AW'(addr);
        local_size       = 3'(size);
        local_write_req  = 1'b0;
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        wait_ready(u);
        for (int c = u + 1; c <= u + RL + n - 1; c++) busy[c] = 1'b1;
        for (int j = 0; j < n; j++) begin
            rv[u + RL + j] = 1'b1;
            rd[u + RL + j] = mmem[(addr + j) % MD];
        end
        next_cycle();
        local_read_req   = 1'b0;
        local_burstbegin = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, u, t2;
        next_cycle();
        next_cycle();
        init_start = cyc;
        chk_en     = 1'b1;
        rst        = 1'b0;

        step_to(init_start + 15);
        chk("init_low_c15", {31'b0, local_init_done}, 32'd0);
        next_cycle();
        chk("init_high_c16", {31'b0, local_init_done}, 32'd1);
        chk("ready_c16", {31'b0, local_ready}, 32'd1);

        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'hA000_00A0 + k;
            wbe[k]  = 4'hF;
        end
        do_write(32'h10, 4, 1'b0, t);
        chk("wr_ready_back_latency", cyc - t, 32'd6);
        chk("wr_ready_back", {31'b0, local_ready}, 32'd1);

        do_read(32'h10, 4, u);
        step_to(u + 4);
        chk("rd_first_valid", {31'b0, local_rdata_valid}, 32'd1);
        chk("rd_beat0", local_rdata, 32'hA000_00A0);
        step_to(u + 7);
        chk("rd_beat3", local_rdata, 32'hA000_00A3);
        step_to(u + 8);
        chk("rd_ready_back", {31'b0, local_ready}, 32'd1);
        chk("rd_valid_off", {31'b0, local_rdata_valid}, 32'd0);

        wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
        do_write(5, 1, 1'b0, t);
        wdat[0] = 32'h1234_5678; wbe[0] = 4'b0101;
        do_write(5, 0, 1'b0, t);
        chk("size0_ready_latency", cyc - t, 32'd3);
        chk("model_be_merge", mmem[5], 32'hFF34_FF78);
        do_read(5, 0, u);
        step_to(u + 4);
        chk("be_read", local_rdata, 32'hFF34_FF78);
        step_to(u + 5);
        chk("size0_single_beat", {31'b0, local_rdata_valid}, 32'd0);

        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'hB000_00B0 + k;
            wbe[k]  = 4'hF;
        end
        do_write(MD - 2, 4, 1'b0, t);
        do_read(MD - 2, 4, u);
        step_to(u + 6);
        chk("wrap_beat_at_0", local_rdata, 32'hB000_00B2);
        step_to(u + 8);

        local_address  = AW'(32'h10);
        local_size     = 3'd1;
        local_read_req = 1'b1;
        for (int k = 0; k < 3; k++) next_cycle();
        local_read_req  = 1'b0;
        local_write_req = 1'b1;
        for (int k = 0; k < 3; k++) next_cycle();
        local_write_req = 1'b0;
        chk("no_bb_ignored", {31'b0, local_ready}, 32'd1);

        wdat[0] = 32'hC000_00C0; wbe[0] = 4'hF;
        wdat[1] = 32'hC000_00C1; wbe[1] = 4'hF;
        do_write(32'h40, 2, 1'b1, t);
        do_read(32'h40, 2, t2);
        chk("simul_read_accept", t2 - t, 32'd4);
        step_to(t2 + 4);
        chk("simul_raw_beat0", local_rdata, 32'hC000_00C0);
        step_to(t2 + 6);

        do_read(32'h10, 4, u);
        step_to(u + 5);
        rst = 1'b1;
        next_cycle();
        init_start = cyc;
        for (int c = cyc; c < MAXC; c++) begin
            busy[c] = 1'b0;
            wreq[c] = 1'b0;
            rv[c]   = 1'b0;
        end
        rst = 1'b0;
        chk("rst_valid_off", {31'b0, local_rdata_valid}, 32'd0);
        chk("rst_init_off", {31'b0, local_init_done}, 32'd0);
        step_to(init_start + 15);
        chk("reinit_low_c15", {31'b0, local_init_done}, 32'd0);
        next_cycle();
        chk("reinit_high_c16", {31'b0, local_init_done}, 32'd1);

        do_read(32'h11, 1, u);
        step_to(u + 4);
        chk("ram_kept_after_rst", local_rdata, 32'hA000_00A1);
        step_to(u + 8);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr2_local_responder.md
Name: ddr2_local_responder

Overview:
Synthesizable responder for the DDR2 controller local interface: the target side of the handshake that the burst master drives. It stands in for the DDR2 controller IP, backed by on-chip RAM. It serves local_write_req and local_read_req bursts with the same local_ready, local_wdata_req and local_rdata_valid timing as the controller. This lets the burst master and the ad→ram→wavelet FIFO path run in simulation, and on boards without DDR, without the PHY.

Parameters:
DATA_WIDTH, 32, local data width in bits.
ADDR_WIDTH, 25, local word-address width.
MEM_AW, 10, backing RAM word-address bits (depth 2^MEM_AW); only local_address[MEM_AW-1:0] is used.
INIT_CYCLES, 16, cycles after reset release before local_init_done rises.
RD_LATENCY, 4, cycles from read accept to first local_rdata_valid; minimum 2.
REFRESH_PERIOD, 64, optional-feature stall period in cycles.
REFRESH_STALL, 8, optional-feature stall length in cycles.

Ports:
phy_clk  in  1  sole clock.
rst  in  1  synchronous, active-high reset.
local_address  in  ADDR_WIDTH  burst start word address.
local_write_req  in  1  write command request.
local_read_req  in  1  read command request.
local_burstbegin  in  1  first cycle of a command; required for accept.
local_size  in  3  burst length in beats.
local_wdata  in  DATA_WIDTH  write data, sampled one cycle after each local_wdata_req.
local_be  in  DATA_WIDTH/8  per-byte write enables, sampled with local_wdata.
local_ready  out  1  responder can accept a command this cycle.
local_wdata_req  out  1  request for one write beat.
local_rdata  out  DATA_WIDTH  read data.
local_rdata_valid  out  1  local_rdata valid this cycle.
local_init_done  out  1  initialisation complete.

Behaviour:
- Reset: all outputs are 0. FSM goes to INIT; init counter is cleared. RAM contents are not cleared. Reset in any state aborts the burst in progress and restarts INIT; a partial write keeps the beats already written.
- INIT: counts INIT_CYCLES, then local_init_done=1 (it stays 1 until the next reset). Goes to IDLE.
- local_ready = (state==IDLE) & local_init_done & ~stall. It is a decode of registered state.
- Accept at cycle T: local_ready & local_burstbegin & (local_write_req | local_read_req). At accept, latch the address low bits and the beat count N.
  - N = local_size, except local_size=0 gives N=1.
  - If both requests are high, the write is accepted and the read is not consumed.
  - A request without local_burstbegin is ignored.
- Write path:
  - WR_DATA: local_wdata_req=1 on T+1..T+N.
  - Beat k (k=0..N-1) is sampled at T+2+k and written to addr+k. Bytes with local_be=0 are unchanged.
  - WR_LAST at T+N+1 captures the final beat. IDLE at T+N+2, where local_ready returns.
- Read path:
  - RD_WAIT: hold until T+RD_LATENCY.
  - RD_DATA: local_rdata_valid=1 on T+RD_LATENCY..T+RD_LATENCY+N-1, carrying addr, addr+1, …
  - local_rdata holds its last value when not valid.
  - IDLE and local_ready at T+RD_LATENCY+N.
- Address arithmetic: addr+k is taken modulo 2^MEM_AW and wraps silently. Upper address bits are ignored.
- Outstanding commands: only one at a time. local_ready stays low for the whole burst, so there are no back-to-back accepts inside a burst.
- Read-after-write: data written in a burst is visible to any read accepted after that burst returns to IDLE.

Optional Feature:
RESP_REFRESH_STALL_EN
- Defined: a free-running counter starts at local_init_done. Every REFRESH_PERIOD cycles it raises a stall request.
  - The stall begins only when the FSM is in IDLE; if a burst is in progress it is deferred until return to IDLE.
  - The stall holds local_ready=0 for REFRESH_STALL cycles.
  - A command presented during a stall is not accepted and must be held by the initiator.
- Undefined: stall is tied to 0; local_ready depends only on state and init.

Test Plan:
- Init: deassert rst at cycle 0 → local_init_done=0 through cycle 15, 1 at cycle 16; local_ready=1 at cycle 16.
- Write then read, size 4:
  - Write addr 0x10, data A0..A3, be=F, accepted at T → wdata_req high T+1..T+4; local_ready back at T+6.
  - Read addr 0x10 accepted at U → rdata_valid U+4..U+7 with A0..A3; local_ready at U+8.
- Byte enables and size 0:
  - Write 0xFFFFFFFF to addr 5, then write 0x12345678 to addr 5 with be=4'b0101 and size 0 (one beat).
  - Read addr 5 → 0xFF34FF78, single valid beat.
- Wrap: write 4 beats at addr 2^MEM_AW-2 (1022) → read at 1022, size 4, returns the beats in order, from 1022, 1023, 0, 1.
- Simultaneous requests: write_req and read_req high together with burstbegin → write executes; read accepted only once local_ready returns.
- Reset mid-read: rst pulsed at U+5 during a size-4 read → rdata_valid=0 and local_init_done=0 the next cycle; re-init takes 16 cycles.
- With RESP_REFRESH_STALL_EN: an idle bench sees local_ready low for 8 cycles every 64 cycles.
